// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop input synchroniser, start/data/stop/break
// sequencer and a single-entry holding register with a valid/ready handshake.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       io_clock,
   input  logic       io_rst_n,
   input  logic       io_uart_rxd,
   output logic       io_rxData_valid,
   input  logic       io_rxData_ready,
   output logic [7:0] io_rxData_bits,
   output logic       io_frameErr,
   output logic       io_overrun,
   output logic       io_busy
);

   localparam int CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int HALF_BIT  = CLKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shreg, shreg_nxt;

   logic rxd_p0, rxd_p1, rxd_s;
   logic stop_ok, stop_bad;
   logic done_p0, ferr_p0;
   logic take, load;

   // Stage p0/p1: metastability synchroniser, idles high so reset looks like a quiet line
   always_ff @(posedge io_clock or negedge io_rst_n) begin
      if (!io_rst_n) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
      end else begin
         rxd_p0 <= io_uart_rxd;
         rxd_p1 <= rxd_p0;
      end
   end

   assign rxd_s = rxd_p1;

   always_ff @(posedge io_clock or negedge io_rst_n) begin
      if (!io_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_nxt = START;
               cnt_nxt   = CNT_ZERO;
            end
         end
         START: begin
            // Re-check the line half a bit in; a high level here was a glitch
            if (cnt == CNT_MID) begin
               cnt_nxt   = CNT_ZERO;
               idx_nxt   = 3'd0;
               state_nxt = rxd_s ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = CNT_ZERO;
               shreg_nxt = {rxd_s, shreg[7:1]};
               if (idx == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = CNT_ZERO;
               state_nxt = rxd_s ? IDLE : BREAK;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         BREAK: begin
            if (rxd_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   always_comb begin
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      io_busy  = (state != IDLE);
      if (state == STOP && cnt == CNT_LAST) begin
         stop_ok  = rxd_s;
         stop_bad = !rxd_s;
      end
   end

   // Stage p0: stop-bit verdict registered one cycle ahead of delivery
   always_ff @(posedge io_clock or negedge io_rst_n) begin
      if (!io_rst_n) begin
         done_p0 <= 1'b0;
         ferr_p0 <= 1'b0;
      end else begin
         done_p0 <= stop_ok;
         ferr_p0 <= stop_bad;
      end
   end

   assign take = io_rxData_valid && io_rxData_ready;
   assign load = done_p0 && (!io_rxData_valid || take);

   // Stage p1: holding register and one-cycle error pulses
   always_ff @(posedge io_clock or negedge io_rst_n) begin
      if (!io_rst_n) begin
         io_rxData_valid <= 1'b0;
         io_rxData_bits  <= '0;
         io_frameErr     <= 1'b0;
         io_overrun      <= 1'b0;
      end else begin
         io_frameErr <= ferr_p0;
         io_overrun  <= done_p0 && !load;
         if (load) begin
            io_rxData_valid <= 1'b1;
            io_rxData_bits  <= shreg;
         end else if (take) begin
            io_rxData_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: reset, good frame, glitch,
// framing error, overrun and reset in the middle of a frame.
module tb_uart_rx;

   localparam int N = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       rxd   = 1'b1;
   logic       ready = 1'b0;
   logic       valid;
   logic [7:0] bits;
   logic       ferr;
   logic       ovr;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .io_clock        (clk),
      .io_rst_n        (rst_n),
      .io_uart_rxd     (rxd),
      .io_rxData_valid (valid),
      .io_rxData_ready (ready),
      .io_rxData_bits  (bits),
      .io_frameErr     (ferr),
      .io_overrun      (ovr),
      .io_busy         (busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event counters sampled on the falling edge, away from the active edge
   int   vld_rise_cyc = 0;
   int   vld_rises    = 0;
   int   vld_cycles   = 0;
   int   fe_pulses    = 0;
   int   ov_pulses    = 0;
   int   busy_cycles  = 0;
   int   nz_cycles    = 0;
   logic prev_v       = 1'b0;

   always @(negedge clk) begin
      if (valid === 1'b1 && prev_v !== 1'b1) begin
         vld_rise_cyc <= cyc;
         vld_rises    <= vld_rises + 1;
      end
      prev_v <= valid;
      if (valid === 1'b1) vld_cycles  <= vld_cycles + 1;
      if (ferr === 1'b1)  fe_pulses   <= fe_pulses + 1;
      if (ovr === 1'b1)   ov_pulses   <= ov_pulses + 1;
      if (busy === 1'b1)  busy_cycles <= busy_cycles + 1;
      if (valid !== 1'b0 || ferr !== 1'b0 || ovr !== 1'b0 || busy !== 1'b0 || bits !== 8'h00)
         nz_cycles <= nz_cycles + 1;
   end

   int n_checks = 0;
   int n_errors = 0;
   int start_c  = 0;
   int s_vr, s_vc, s_fe, s_ov, s_busy, s_nz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      s_vr   = vld_rises;
      s_vc   = vld_cycles;
      s_fe   = fe_pulses;
      s_ov   = ov_pulses;
      s_busy = busy_cycles;
      s_nz   = nz_cycles;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      step(N);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      start_c = cyc + 1;
      send_bit(1'b0);
      for (int k = 0; k < 8; k++) send_bit(b[k]);
      send_bit(stop);
   endtask

   initial begin
      // Reset: hold 5 cycles, then 100 idle cycles with every output low
      #1;
      rst_n = 1'b0;
      snap();
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      step(5);
      rst_n = 1'b1;
      step(100);
      chk("rst_idle_outputs", nz_cycles - s_nz, 32'd0);

      // Good frame 0xA5, consumer always ready
      ready = 1'b1;
      snap();
      send_byte(8'hA5, 1'b1);
      step(4);
      chk("good_latency", vld_rise_cyc - start_c, 32'd155);
      chk("good_vld_cycles", vld_cycles - s_vc, 32'd1);
      chk("good_bits", {24'd0, bits}, 32'h0000_00A5);
      chk("good_ferr", fe_pulses - s_fe, 32'd0);
      chk("good_ovr", ov_pulses - s_ov, 32'd0);

      // Glitch: 4-cycle low pulse never leaves START
      step(10);
      snap();
      rxd = 1'b0;
      step(4);
      rxd = 1'b1;
      step(30);
      chk("glitch_busy_bounded",
          {31'd0, (busy_cycles - s_busy >= 1) && (busy_cycles - s_busy <= 10)}, 32'd1);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
      chk("glitch_no_valid", vld_rises - s_vr, 32'd0);
      chk("glitch_no_ferr", fe_pulses - s_fe, 32'd0);

      // Framing error on 0x3C, line held low afterwards
      snap();
      send_byte(8'h3C, 1'b0);
      step(64);
      chk("fe_pulse_count", fe_pulses - s_fe, 32'd1);
      chk("fe_no_valid", vld_rises - s_vr, 32'd0);
      chk("fe_busy_in_break", {31'd0, busy}, 32'd1);
      rxd = 1'b1;
      step(6);
      chk("fe_break_exit", {31'd0, busy}, 32'd0);
      step(10);
      snap();
      send_byte(8'h3C, 1'b1);
      step(4);
      chk("fe_recover_valid", vld_rises - s_vr, 32'd1);
      chk("fe_recover_bits", {24'd0, bits}, 32'h0000_003C);
      chk("fe_recover_no_ferr", fe_pulses - s_fe, 32'd0);

      // Overrun: consumer stalled across two back-to-back frames
      ready = 1'b0;
      step(10);
      snap();
      send_byte(8'h11, 1'b1);
      chk("ovr_first_valid", {31'd0, valid}, 32'd1);
      chk("ovr_first_bits", {24'd0, bits}, 32'h0000_0011);
      send_byte(8'h22, 1'b1);
      step(4);
      chk("ovr_pulse_count", ov_pulses - s_ov, 32'd1);
      chk("ovr_still_valid", {31'd0, valid}, 32'd1);
      chk("ovr_kept_bits", {24'd0, bits}, 32'h0000_0011);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      chk("ovr_drain_valid", {31'd0, valid}, 32'd0);
      chk("ovr_drain_bits", {24'd0, bits}, 32'h0000_0011);
      step(1);
      chk("ovr_no_ferr", fe_pulses - s_fe, 32'd0);

      // Reset asserted during data bit 3 of 0xFF
      ready = 1'b1;
      step(10);
      send_bit(1'b0);
      for (int k = 0; k < 3; k++) send_bit(1'b1);
      rxd = 1'b1;
      step(N / 2);
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_busy_reset", {31'd0, busy}, 32'd0);
      chk("mid_bits_reset", {24'd0, bits}, 32'd0);
      step(3);
      rst_n = 1'b1;
      step(20);
      snap();
      send_byte(8'h5A, 1'b1);
      step(4);
      chk("mid_after_valid", vld_rises - s_vr, 32'd1);
      chk("mid_after_bits", {24'd0, bits}, 32'h0000_005A);
      chk("mid_after_ferr", fe_pulses - s_fe, 32'd0);
      chk("mid_after_ovr", ov_pulses - s_ov, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the input-direction counterpart of the UART transmit path that drives `io_uart_txd`. It synchronises the asynchronous `io_uart_rxd` line and decodes 8N1 frames (1 start, 8 data LSB-first, 1 stop). Each good byte goes to a single-entry holding register with a valid/ready handshake. It sits between the `io_uart_rxd` pad of `Top` and the SoC's UART MMIO register block, and reports framing and overrun errors.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per UART bit, written N below. Legal range N >= 4.

Ports:
- `io_clock`  in  1  sole clock; all logic is on its rising edge.
- `io_rst_n`  in  1  reset, asynchronous and active-low.
- `io_uart_rxd`  in  1  serial input, asynchronous to `io_clock`, idle high.
- `io_rxData_valid`  out  1  holding register contains an unread byte.
- `io_rxData_ready`  in  1  consumer accepts the byte.
- `io_rxData_bits`  out  8  received byte; stable while valid is high.
- `io_frameErr`  out  1  one-cycle pulse: stop bit sampled as 0.
- `io_overrun`  out  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- `io_busy`  out  1  FSM is in any state other than IDLE.

## Operation
- **Synchroniser:** two flops, both reset to 1. The FSM sees only `rxd_s`.
- **Counter:** bit counter `cnt`, width $clog2(N).
- **Bit index:** `idx`, 3 bits.
- **Shift register:** `shreg`, 8 bits, shifted right; each new bit enters at bit 7.
- **States:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** when `rxd_s`==0, go to START with cnt=0.
  - **START:** count up to floor(N/2)-1. At that count:
    - `rxd_s`==0: go to DATA, cnt=0, idx=0.
    - `rxd_s`==1: the low pulse was a glitch. Go to IDLE with no outputs.
  - **DATA:** at cnt==N-1, sample `rxd_s` into shreg and set cnt=0. After idx==7 is sampled, go to STOP; otherwise increment idx.
  - **STOP:** at cnt==N-1, sample `rxd_s`.
    - Sample is 1: good byte. Go to IDLE.
    - Sample is 0: pulse `io_frameErr`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rxd_s`==1, then go to IDLE. No start bit is detected while the line stays low.
- **Delivering a good byte**, registered on the cycle after the stop sample:
  - Holding register empty, or handshake (valid & ready) in that same cycle: load bits=shreg and set valid=1.
  - Otherwise: keep the old byte, drop the new one, pulse `io_overrun`.
- **Handshake:** a transfer occurs on any cycle with valid & ready. valid clears on the next cycle unless a new byte loads in that same cycle, in which case valid stays 1.
- **Ready without valid:** `io_rxData_ready` has no effect when valid is low.

## Timing
- **Reset:** while `io_rst_n`=0, all outputs are 0, the FSM is in IDLE, cnt, idx and shreg are 0, and both synchroniser flops are 1. Reset takes effect immediately, including mid-frame. A partial frame is discarded without any error pulse.
- **Synchroniser delay:** 2 cycles from the pin to `rxd_s`.
- **Falling-edge reference:** let cycle 0 be the first rising edge that samples the pin low.
  - Start bit checked at cycle 2+floor(N/2).
  - Data bit k sampled at cycle 2+floor(N/2)+(k+1)·N.
  - Stop bit sampled at cycle 2+floor(N/2)+9N.
  - `io_rxData_valid` high, or the error pulse, at cycle 3+floor(N/2)+9N.
- **Back-to-back frames:** a new start bit is detected the cycle after STOP→IDLE. Frames with a full stop bit receive back-to-back without loss.
- **Pulse width:** `io_frameErr` and `io_overrun` are high for exactly 1 cycle.
- **Glitch rejection:** low pulses shorter than floor(N/2) cycles at `rxd_s` never leave START.

## Test plan
All scenarios use N=16.
- **Reset:** hold `io_rst_n`=0 for 5 cycles with rxd=1, then release and idle for 100 cycles -> every output is 0 throughout.
- **Good frame:** send 0xA5 with stop=1 and ready=1 -> valid is high for 1 cycle at cycle 3+8+144=155 after the start edge. bits=0xA5, frameErr=0, overrun=0.
- **Glitch:** drive rxd low for 4 cycles, then high -> busy for at most 10 cycles, then IDLE. No valid and no error pulse.
- **Framing error:** send 0x3C with stop=0, then keep rxd low for 64 more cycles -> one frameErr pulse and valid stays 0. busy stays 1 until rxd returns high. A following 0x3C frame is then received correctly.
- **Overrun:** hold ready=0 and send 0x11 then 0x22 back-to-back -> valid=1 with bits=0x11. One overrun pulse when 0x22 completes. Then raise ready for 1 cycle -> valid drops and bits remain 0x11.
- **Reset mid-frame:** assert reset during data bit 3 of 0xFF -> outputs go to 0 at once. After release, a sent 0x5A gives one valid with bits=0x5A and no error pulses.
